// File: rtl/regfile_write_ctrl_if.sv
// Write-port bundle for the register file controller: pipeline writeback, debug requester,
// and the register-file write port with status flags.
interface regfile_write_ctrl_if #(
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned DATA_W = 8
);
   logic              init_req;
   logic              wb_we;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              dbg_req;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_data;
   logic              dbg_gnt;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_data;
   logic              init_busy;
   logic              pipe_stall;

   // Requesters (pipeline + debug) drive the request side.
   modport master (
      output init_req, wb_we, wb_addr, wb_data, dbg_req, dbg_addr, dbg_data,
      input  dbg_gnt, rf_we, rf_addr, rf_data, init_busy, pipe_stall
   );

   // The controller serves requests and owns the register-file write port.
   modport slave (
      input  init_req, wb_we, wb_addr, wb_data, dbg_req, dbg_addr, dbg_data,
      output dbg_gnt, rf_we, rf_addr, rf_data, init_busy, pipe_stall
   );
endinterface

// File: rtl/regfile_write_ctrl.sv
// Single write-port owner for the register file: default-load sequencer after reset/init_req,
// WB-priority arbitration against a debug requester, and a starvation stall for debug.
module regfile_write_ctrl #(
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned MAX_WAIT = 4
) (
   input logic                 clk,
   input logic                 reset,
   regfile_write_ctrl_if.slave bus
);

   localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      StInit,
      StRun,
      StStarve
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
   logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
   logic              rf_we_q, rf_we_d;
   logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_W-1:0] rf_data_q, rf_data_d;
   logic              dbg_gnt_q, dbg_gnt_d;
   logic              init_busy_q, init_busy_d;
   logic              pipe_stall_q, pipe_stall_d;

   logic              dbg_pending;
   logic              init_last;
   logic [WaitW-1:0]  wait_inc;

   // A request seen during the grant cycle is the requester's turnaround, not a new request.
   assign dbg_pending = bus.dbg_req & ~dbg_gnt_q;
   assign init_last   = (init_cnt_q == ADDR_W'(NUM_REGS - 1));
   assign wait_inc    = (wait_cnt_q == WaitW'(MAX_WAIT)) ? wait_cnt_q
                                                         : wait_cnt_q + WaitW'(1);

   always_comb begin
      state_d      = state_q;
      init_cnt_d   = init_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      rf_we_d      = 1'b0;
      rf_addr_d    = rf_addr_q;
      rf_data_d    = rf_data_q;
      dbg_gnt_d    = 1'b0;
      init_busy_d  = 1'b0;
      pipe_stall_d = 1'b0;

      if ((state_q != StInit) && bus.init_req) begin
         // Restart the default load; a same-cycle WB write still lands, debug waits.
         state_d      = StInit;
         init_cnt_d   = '0;
         wait_cnt_d   = '0;
         init_busy_d  = 1'b1;
         pipe_stall_d = 1'b1;
         if (bus.wb_we) begin
            rf_we_d   = 1'b1;
            rf_addr_d = bus.wb_addr;
            rf_data_d = bus.wb_data;
         end
      end else begin
         unique case (state_q)
            StInit: begin
               rf_we_d      = 1'b1;
               rf_addr_d    = init_cnt_q;
               rf_data_d    = DATA_W'(init_cnt_q);
               init_cnt_d   = init_cnt_q + ADDR_W'(1);
               // Busy/stall stay up until the edge after the last init write.
               init_busy_d  = 1'b1;
               pipe_stall_d = 1'b1;
               if (init_last) begin
                  state_d = StRun;
               end
            end

            StRun: begin
               if (bus.wb_we) begin
                  rf_we_d   = 1'b1;
                  rf_addr_d = bus.wb_addr;
                  rf_data_d = bus.wb_data;
                  if (dbg_pending) begin
                     wait_cnt_d = wait_inc;
                     if (wait_inc == WaitW'(MAX_WAIT)) begin
                        state_d      = StStarve;
                        pipe_stall_d = 1'b1;
                     end
                  end else if (!bus.dbg_req) begin
                     wait_cnt_d = '0;
                  end
               end else if (dbg_pending) begin
                  rf_we_d    = 1'b1;
                  rf_addr_d  = bus.dbg_addr;
                  rf_data_d  = bus.dbg_data;
                  dbg_gnt_d  = 1'b1;
                  wait_cnt_d = '0;
               end else if (!bus.dbg_req) begin
                  wait_cnt_d = '0;
               end
            end

            StStarve: begin
               if (bus.wb_we) begin
                  // WB during stall is a requester bug; honour it and keep stalling.
                  rf_we_d      = 1'b1;
                  rf_addr_d    = bus.wb_addr;
                  rf_data_d    = bus.wb_data;
                  pipe_stall_d = 1'b1;
               end else if (dbg_pending) begin
                  rf_we_d    = 1'b1;
                  rf_addr_d  = bus.dbg_addr;
                  rf_data_d  = bus.dbg_data;
                  dbg_gnt_d  = 1'b1;
                  wait_cnt_d = '0;
                  state_d    = StRun;
               end else begin
                  wait_cnt_d = '0;
                  state_d    = StRun;
               end
            end

            default: begin
               state_d      = StInit;
               init_cnt_d   = '0;
               wait_cnt_d   = '0;
               init_busy_d  = 1'b1;
               pipe_stall_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StInit;
         init_cnt_q   <= '0;
         wait_cnt_q   <= '0;
         rf_we_q      <= 1'b0;
         rf_addr_q    <= '0;
         rf_data_q    <= '0;
         dbg_gnt_q    <= 1'b0;
         init_busy_q  <= 1'b1;
         pipe_stall_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         init_cnt_q   <= init_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         rf_we_q      <= rf_we_d;
         rf_addr_q    <= rf_addr_d;
         rf_data_q    <= rf_data_d;
         dbg_gnt_q    <= dbg_gnt_d;
         init_busy_q  <= init_busy_d;
         pipe_stall_q <= pipe_stall_d;
      end
   end

   assign bus.rf_we      = rf_we_q;
   assign bus.rf_addr    = rf_addr_q;
   assign bus.rf_data    = rf_data_q;
   assign bus.dbg_gnt    = dbg_gnt_q;
   assign bus.init_busy  = init_busy_q;
   assign bus.pipe_stall = pipe_stall_q;

`ifndef SYNTHESIS
   a_gnt_writes : assert property (@(posedge clk) disable iff (!reset) dbg_gnt_q |-> rf_we_q);
   a_busy_stall : assert property (@(posedge clk) disable iff (!reset) init_busy_q |-> pipe_stall_q);
`endif

endmodule
